// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx : 8N1 receiver, two-flop synchronized input, mid-bit sampling.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned CLK_FREQ = 12000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // The counter restarts at every sample point so timing never drifts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx : drives 8N1 frames into two receivers (115200 and 9600 baud) and
// checks every cycle against a frame-level event model.
module tb_uart_rx;

  localparam int CPB_F = 104;
  localparam int CPB_S = 1250;
  localparam int LAT_F = 2 + CPB_F / 2 + 9 * CPB_F;
  localparam int LAT_S = 2 + CPB_S / 2 + 9 * CPB_S;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_slow = 1'b1;
  wire  [7:0] data, data_s;
  wire        valid, valid_s, frame_err, frame_err_s, busy, busy_s;

  uart_rx dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  uart_rx #(.CLK_FREQ(12000000), .BAUD(9600)) dut_slow (
    .clk(clk), .rst(rst), .rx(rx_slow),
    .data(data_s), .valid(valid_s), .frame_err(frame_err_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    bit         err;
    logic [7:0] d;
  } ev_t;

  ev_t        q_f[$];
  ev_t        q_s[$];
  logic [7:0] mdl_f = 8'h00;
  logic [7:0] mdl_s = 8'h00;
  int         n_chk = 0;
  int         n_err = 0;
  int         last_vf = -1, prev_vf = -1, last_vs = -1;
  int         vcnt_f = 0, ferr_cnt_f = 0;
  bit         busy_hist [0:39999];
  bit         chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected pulse for a frame lands a fixed latency after its start sample.
  initial begin
    ev_t  ev;
    logic ev_v, ev_e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ev_v = 1'b0;
        ev_e = 1'b0;
        if (q_f.size() > 0 && q_f[0].t == cyc) begin
          ev = q_f.pop_front();
          if (ev.err) ev_e = 1'b1;
          else begin ev_v = 1'b1; mdl_f = ev.d; end
        end
        chk("fast_outputs", 32'({valid, frame_err, data}), 32'({ev_v, ev_e, mdl_f}));
        if (valid === 1'b1) begin prev_vf = last_vf; last_vf = cyc; vcnt_f++; end
        if (frame_err === 1'b1) ferr_cnt_f++;
        if (cyc < 40000) busy_hist[cyc] = busy;

        ev_v = 1'b0;
        ev_e = 1'b0;
        if (q_s.size() > 0 && q_s[0].t == cyc) begin
          ev = q_s.pop_front();
          if (ev.err) ev_e = 1'b1;
          else begin ev_v = 1'b1; mdl_s = ev.d; end
        end
        chk("slow_outputs", 32'({valid_s, frame_err_s, data_s}), 32'({ev_v, ev_e, mdl_s}));
        if (valid_s === 1'b1) last_vs = cyc;
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit slow,
                            input int abort_bit, output int s);
    int  cpb;
    ev_t ev;
    cpb  = slow ? CPB_S : CPB_F;
    s    = cyc + 1;
    ev.t = s + (slow ? LAT_S : LAT_F);
    ev.err = ~stop_bit;
    ev.d = b;
    if (slow) q_s.push_back(ev); else q_f.push_back(ev);
    if (slow) rx_slow = 1'b0; else rx = 1'b0;
    repeat (cpb) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (slow) rx_slow = b[i]; else rx = b[i];
      if (i == abort_bit) begin
        repeat (cpb / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_f.delete();
        q_s.delete();
        mdl_f = 8'h00;
        mdl_s = 8'h00;
        rx = 1'b1;
        rx_slow = 1'b1;
        return;
      end
      repeat (cpb) @(posedge clk);
      #1;
    end
    if (slow) rx_slow = stop_bit; else rx = stop_bit;
    repeat (cpb) @(posedge clk);
    #1;
  endtask

  initial begin
    int s, s1, s2;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_busy_slow", 32'(busy_s), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send_frame(8'h41, 1'b1, 1'b0, -1, s);
    repeat (20) @(posedge clk);
    #1;
    chk("latency_0x41", 32'(last_vf - s), 32'd990);
    chk("data_0x41", 32'(data), 32'h41);
    chk("no_frame_err_0x41", 32'(ferr_cnt_f), 32'd0);

    s = cyc + 1;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("glitch_busy_s+1", 32'(busy_hist[s + 1]), 32'd0);
    chk("glitch_busy_s+2", 32'(busy_hist[s + 2]), 32'd1);
    chk("glitch_busy_s+53", 32'(busy_hist[s + 53]), 32'd1);
    chk("glitch_busy_s+54", 32'(busy_hist[s + 54]), 32'd0);
    chk("glitch_valid_count", 32'(vcnt_f), 32'd1);
    chk("glitch_data", 32'(data), 32'h41);

    send_frame(8'h5A, 1'b0, 1'b0, -1, s);
    repeat (2000) @(posedge clk);
    #1;
    chk("break_busy_held", 32'(busy), 32'd1);
    chk("break_frame_err_count", 32'(ferr_cnt_f), 32'd1);
    chk("break_data_kept", 32'(data), 32'h41);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("break_busy_released", 32'(busy), 32'd0);
    chk("break_frame_err_final", 32'(ferr_cnt_f), 32'd1);
    repeat (20) @(posedge clk);
    #1;

    send_frame(8'h30, 1'b1, 1'b0, -1, s1);
    send_frame(8'h39, 1'b1, 1'b0, -1, s2);
    repeat (20) @(posedge clk);
    #1;
    chk("b2b_first_latency", 32'(prev_vf - s1), 32'd990);
    chk("b2b_spacing", 32'(last_vf - prev_vf), 32'd1040);
    chk("b2b_data", 32'(data), 32'h39);

    send_frame(8'h55, 1'b1, 1'b0, 4, s);
    chk("abort_data", 32'(data), 32'h00);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_frame_err", 32'(frame_err), 32'd0);
    repeat (1200) @(posedge clk);
    #1;
    chk("abort_valid_count", 32'(vcnt_f), 32'd3);
    send_frame(8'h21, 1'b1, 1'b0, -1, s);
    repeat (20) @(posedge clk);
    #1;
    chk("after_abort_data", 32'(data), 32'h21);
    chk("after_abort_valid_count", 32'(vcnt_f), 32'd4);

    send_frame(8'hFF, 1'b1, 1'b1, -1, s);
    repeat (30) @(posedge clk);
    #1;
    chk("slow_latency", 32'(last_vs - s), 32'd11877);
    chk("slow_data", 32'(data_s), 32'hFF);
    chk("slow_queue_drained", 32'(q_s.size()), 32'd0);
    chk("fast_queue_drained", 32'(q_f.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 12000000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter BAUD, default 115200, meaning the line bit rate.
REQ-003 The module SHALL derive local CLKS_PER_BIT = CLK_FREQ/BAUD (integer truncation; 104 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (52 at defaults).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 The module SHALL have port data, output, 8 bits: last correctly framed byte.
REQ-008 The module SHALL have port valid, output, 1 bit: one-cycle pulse when data updates.
REQ-009 The module SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 The module SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 The module SHALL pass rx through two flip-flops (rx_s) before any use; no other logic sees raw rx.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: when rx_s = 0, go to START and clear the bit-period counter; otherwise stay.
REQ-014 START: at the HALF_BIT-th cycle, sample rx_s; if 1 (glitch), return to IDLE with no output pulse; if 0, go to DATA.
REQ-015 DATA: sample rx_s every CLKS_PER_BIT cycles, shifting LSB first; after the 8th sample, go to STOP.
REQ-016 STOP: sample rx_s after CLKS_PER_BIT cycles. If 1: load data from the shift register, pulse valid, go to IDLE in the same edge. If 0: pulse frame_err, leave data unchanged, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: stay until rx_s = 1, then go to IDLE; a held-low break SHALL produce exactly one frame_err and no further pulses.
REQ-018 Latency: valid/frame_err SHALL assert exactly 2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the first clk edge at which rx is sampled low (990 at defaults).
REQ-019 valid and frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-020 data SHALL hold its value between valid pulses.
REQ-021 A start bit beginning immediately after the stop-bit sample (no idle gap) SHALL be received correctly.
REQ-022 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL restart at each sample point, so no drift accumulates within a frame.
REQ-023 busy SHALL be 0 only in IDLE; it SHALL be 1 in START, DATA, STOP and WAIT_HIGH.

Reset
REQ-024 While rst = 1 at a clk edge, the block SHALL enter IDLE and set data = 8'h00, valid = 0, frame_err = 0, busy = 0, both synchronizer flops to 1, and counters/shift register to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse.
REQ-026 After reset release, a start SHALL be detected only on rx_s low at or after the first edge following release.

Verification
REQ-027 Send 0x41 at 115200 baud (104 clk/bit) -> valid one cycle at edge 990 after start sample, data = 0x41, frame_err stays 0.
REQ-028 Pulse rx low for 20 cycles, then high -> busy 1 for about 52 cycles, then 0; no valid, no frame_err; data unchanged.
REQ-029 After 0x41, send 0x5A with stop bit = 0, then hold rx low 2000 cycles -> one frame_err pulse; data stays 0x41; busy stays 1 until rx returns high.
REQ-030 Send 0x30 and 0x39 back-to-back with no idle bits -> two valid pulses 1040 cycles apart, data = 0x30 then 0x39.
REQ-031 Assert rst for 1 cycle during bit 4 of 0x55 -> no pulse; outputs at reset values; a following 0x21 is received with data = 0x21.
REQ-032 Instantiate with CLK_FREQ = 12000000 and BAUD = 9600 (1250 clk/bit), send 0xFF -> valid at edge 2 + 625 + 11250 = 11877, data = 0xFF.
